// File: rtl/bitty_result_tx.sv
// bitty_result_tx: queues 16-bit results in a FIFO and sends each one as two
// UART 8N1 frames, low byte first.
module bitty_result_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          done,
    input  logic [15:0]                   d_out,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_next;
    logic [15:0] mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [15:0] hold, baud;
    logic [2:0] bit_idx, bit_idx_next;
    logic byte_sel, byte_sel_next;
    logic tick, pop, push;
    logic [PW:0] count_next;

    assign tick = baud == 16'(CLKS_PER_BIT - 1);
    assign pop = state == IDLE && fifo_count != '0;
    // a pop in the same cycle frees the slot a full FIFO needs
    assign push = done && (fifo_count < FULL || pop);
    assign count_next = fifo_count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

    always_comb begin
        state_next = state;
        bit_idx_next = bit_idx;
        byte_sel_next = byte_sel;
        tx = 1'b1;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_next = START;
                    byte_sel_next = 1'b0;
                end
            end
            START: begin
                tx = 1'b0;
                if (tick) begin
                    state_next = DATA;
                    bit_idx_next = 3'd0;
                end
            end
            DATA: begin
                tx = hold[{byte_sel, bit_idx}];
                if (tick) begin
                    bit_idx_next = bit_idx + 3'd1;
                    state_next = bit_idx == 3'd7 ? STOP : DATA;
                end
            end
            STOP: begin
                if (tick) begin
                    state_next = byte_sel ? IDLE : START;
                    byte_sel_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= d_out;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
            overflow <= 1'b0;
            busy <= 1'b0;
            baud <= '0;
            bit_idx <= '0;
            byte_sel <= 1'b0;
            hold <= '0;
        end else begin
            state <= state_next;
            bit_idx <= bit_idx_next;
            byte_sel <= byte_sel_next;
            fifo_count <= count_next;
            busy <= state_next != IDLE || count_next != '0;
            baud <= (state == IDLE || tick) ? '0 : baud + 16'd1;
            if (done && !push) overflow <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                hold <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bitty_result_tx.sv
// tb_bitty_result_tx: drives two transmitters (4 and 2 clocks per bit) with shared
// stimulus; checks them against a cycle-level queue model and a UART line decoder.
module tb_bitty_result_tx;
    localparam int D = 4;
    logic clk = 0, rst_n = 0, done = 0;
    logic [15:0] d_out = 0;
    logic tx[2], busy[2], overflow[2];
    logic [2:0] cnt[2];
    int n_cmp = 0, n_bad = 0;
    int cpb[2] = '{4, 2};
    logic [15:0] mq[2][$];
    logic [15:0] mcur[2];
    int mleft[2] = '{0, 0};
    logic movf[2] = '{0, 0};
    logic lq[2][$];
    logic [7:0] rx_b[$];
    int rx_at[$];

    typedef struct { logic [15:0] w; logic [7:0] lo; logic [7:0] hi; } vec_t;
    vec_t tv[4];
    int bc[6] = '{1, 1, 2, 3, 4, 4};
    logic [15:0] w4[6];

    always #5 clk = ~clk;

    bitty_result_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(D)) dut4 (
        .clk(clk), .rst_n(rst_n), .done(done), .d_out(d_out),
        .tx(tx[0]), .busy(busy[0]), .overflow(overflow[0]), .fifo_count(cnt[0]));
    bitty_result_tx #(.CLKS_PER_BIT(2), .FIFO_DEPTH(D)) dut2 (
        .clk(clk), .rst_n(rst_n), .done(done), .d_out(d_out),
        .tx(tx[1]), .busy(busy[1]), .overflow(overflow[1]), .fifo_count(cnt[1]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // mleft counts the line-active cycles still to come for the word in flight
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mq[i].delete();
                mleft[i] = 0;
                movf[i] = 1'b0;
            end else begin
                if (mleft[i] > 0) mleft[i]--;
                else if (mq[i].size() > 0) begin
                    mcur[i] = mq[i].pop_front();
                    mleft[i] = 20 * cpb[i];
                end
                if (done) begin
                    if (mq[i].size() < D) mq[i].push_back(d_out);
                    else movf[i] = 1'b1;
                end
            end
        end
    endtask

    function automatic logic mtx(input int i);
        int e, p;
        if (mleft[i] == 0) return 1'b1;
        e = 20 * cpb[i] - mleft[i];
        p = (e % (10 * cpb[i])) / cpb[i];
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return mcur[i][(e / (10 * cpb[i])) * 8 + p - 1];
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("tx cpb=%0d", cpb[i]), tx[i], mtx(i));
            chk($sformatf("busy cpb=%0d", cpb[i]), busy[i], mleft[i] != 0 || mq[i].size() != 0);
            chk($sformatf("overflow cpb=%0d", cpb[i]), overflow[i], movf[i]);
            chk($sformatf("fifo_count cpb=%0d", cpb[i]), cnt[i], mq[i].size());
        end
        lq[0].push_back(tx[0]);
        lq[1].push_back(tx[1]);
    endtask

    task automatic do_reset();
        rst_n = 0;
        done = 0;
        tick();
        rst_n = 1;
        lq[0].delete();
        lq[1].delete();
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while ((busy[0] || busy[1]) && n < bound) begin
            tick();
            n++;
        end
        chk("drain within bound", busy[0] | busy[1], 0);
    endtask

    task automatic decode(input int i);
        int k = 0;
        int c = cpb[i];
        logic [7:0] b;
        rx_b.delete();
        rx_at.delete();
        while (k + 10 * c <= lq[i].size()) begin
            if (lq[i][k] == 1'b0) begin
                for (int j = 0; j < 8; j++) b[j] = lq[i][k + (j + 1) * c + c / 2];
                chk("stop bit", lq[i][k + 9 * c + c / 2], 1);
                rx_b.push_back(b);
                rx_at.push_back(k);
                k += 10 * c;
            end else k++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tv[0] = '{16'hA53C, 8'h3C, 8'hA5};
        tv[1] = '{16'h0000, 8'h00, 8'h00};
        tv[2] = '{16'hFFFF, 8'hFF, 8'hFF};
        tv[3] = '{16'h8001, 8'h01, 8'h80};
        w4 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};

        // reset held with activity on the inputs
        rst_n = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin rst_n = 1; done = 0; end
            else begin done = 1'($urandom_range(0, 1)); d_out = 16'($urandom); end
            tick();
            chk("reset tx", tx[0], 1);
            chk("reset busy", busy[0], 0);
            chk("reset overflow", overflow[0], 0);
            chk("reset fifo_count", cnt[0], 0);
        end

        // single words, both bit rates
        for (int v = 0; v < 4; v++) begin
            int fall[2];
            do_reset();
            done = 1;
            d_out = tv[v].w;
            tick();
            done = 0;
            chk("push latency", cnt[0], 1);
            tick();
            chk("start latency", tx[0], 0);
            fall = '{0, 0};
            for (int n = 2; n < 200 && (busy[0] || busy[1]); n++) begin
                tick();
                for (int i = 0; i < 2; i++) if (!busy[i] && fall[i] == 0) fall[i] = n;
            end
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("busy fall cpb=%0d", cpb[i]), fall[i], 1 + 20 * cpb[i]);
                decode(i);
                chk($sformatf("byte count cpb=%0d", cpb[i]), rx_b.size(), 2);
                if (rx_b.size() >= 2) begin
                    chk("low byte", rx_b[0], tv[v].lo);
                    chk("high byte", rx_b[1], tv[v].hi);
                    chk("low start", rx_at[0], 1);
                    chk("high start", rx_at[1], 1 + 10 * cpb[i]);
                end
            end
        end

        // burst of six with overflow
        do_reset();
        for (int k = 0; k < 6; k++) begin
            done = 1;
            d_out = 16'(k + 1);
            tick();
            chk("burst fifo_count", cnt[0], bc[k]);
            chk("burst overflow", overflow[0], k == 5);
        end
        done = 0;
        drain(2000);
        chk("overflow sticky", overflow[0], 1);
        decode(0);
        chk("burst byte count", rx_b.size(), 10);
        for (int m = 0; m < rx_b.size() && m < 10; m++) begin
            chk("burst byte", rx_b[m], (m % 2) ? 0 : m / 2 + 1);
            if (m > 0) chk("burst spacing", rx_at[m] - rx_at[m - 1], (m % 2) ? 40 : 41);
        end

        // push in the exact pop cycle of a full FIFO
        do_reset();
        for (int k = 0; k < 5; k++) begin
            done = 1;
            d_out = w4[k];
            tick();
        end
        done = 0;
        chk("full count", cnt[0], 4);
        repeat (76) tick();
        chk("last stop bit", tx[0], 1);
        tick();
        chk("idle pop cycle tx", tx[0], 1);
        chk("idle pop cycle count", cnt[0], 4);
        done = 1;
        d_out = w4[5];
        tick();
        done = 0;
        chk("push+pop count", cnt[0], 4);
        chk("push+pop overflow", overflow[0], 0);
        chk("next start bit", tx[0], 0);
        drain(2000);
        decode(0);
        chk("push+pop byte count", rx_b.size(), 12);
        for (int m = 0; m < rx_b.size() && m < 12; m++)
            chk("push+pop byte", rx_b[m], (m % 2) ? w4[m / 2][15:8] : w4[m / 2][7:0]);

        // reset during data bit 3 of the low byte
        do_reset();
        for (int k = 0; k < 3; k++) begin
            done = 1;
            d_out = (k == 0) ? 16'hFFFF : 16'(16'h1234 * (k + 1));
            tick();
        end
        done = 0;
        repeat (16) tick();
        chk("pre-reset count", cnt[0], 2);
        chk("pre-reset busy", busy[0], 1);
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("mid-frame reset tx", tx[0], 1);
        chk("mid-frame reset count", cnt[0], 0);
        chk("mid-frame reset busy", busy[0], 0);
        lq[0].delete();
        lq[1].delete();
        repeat (150) tick();
        for (int i = 0; i < 2; i++) begin
            decode(i);
            chk("frames after reset", rx_b.size(), 0);
        end

        // random traffic with occasional resets
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            int p;
            p = ((n / 500) % 3 == 0) ? 60 : (((n / 500) % 3 == 1) ? 4 : 15);
            done = int'($urandom_range(0, 99)) < p;
            d_out = 16'($urandom);
            rst_n = $urandom_range(0, 599) != 0;
            tick();
        end
        rst_n = 1;
        done = 0;
        drain(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bitty_result_tx.md
# bitty_result_tx

Serial result transmitter for the bitty core. It captures each 16-bit ALU result presented on `d_out` when `done` pulses and queues it in a small FIFO. It then sends each result off-chip as two UART 8N1 frames, low byte first, on one output pin. Instructions enter the design through the instruction memory and program counter; this block is the outbound path.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 87: clock cycles per UART bit. Legal range 2..65535.
- `FIFO_DEPTH`, default 4: result FIFO entries. Must be a power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `done`  in  1  capture strobe from the bitty core. Every cycle it is high is one push request.
- `d_out`  in  16  result word, sampled in any cycle where `done`=1.
- `tx`  out  1  UART line. Idles high.
- `busy`  out  1  high while the FIFO is non-empty or a frame is in progress.
- `overflow`  out  1  sticky. Set when a push is dropped; cleared only by reset.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of words queued, not counting the word being sent.

## Operation

- Reset is sampled only at a clock edge with `rst_n`=0. It overrides all other activity, including an in-flight frame.
  - Reset values: `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0.
  - FSM goes to IDLE. Bit counter, byte select and baud counter all clear to 0.
- FIFO push:
  - A push with `done`=1 is accepted if `fifo_count` < `FIFO_DEPTH`.
  - It is also accepted if the FIFO is full but a pop occurs in the same cycle. The count is then unchanged.
  - Otherwise the word is dropped, `overflow` is set, and the FIFO contents are not altered.
- FIFO pop happens only on the IDLE→START transition. Read and write pointers wrap modulo `FIFO_DEPTH`.
- The FSM has four states: IDLE, START, DATA, STOP. A `byte_sel` flag selects the low byte (0) or high byte (1).
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into a 16-bit shift holding register, clear `byte_sel`, and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `tx` is bit [index] of the selected byte, LSB first, for `CLKS_PER_BIT` cycles per bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. Then:
    - if `byte_sel`=0: set `byte_sel`=1 and go to START, so the high byte follows with no idle gap;
    - if `byte_sel`=1: go to IDLE.
- `busy` = (state ≠ IDLE) OR (`fifo_count` ≠ 0). It is a registered output.
- The word in the holding register is immune to new pushes. Pushes only affect the FIFO.
- If `done` is held high for N cycles, the block makes N push requests. Each push request is subject to the full rule above.

## Timing

- Baud counter runs 0..`CLKS_PER_BIT`-1. The state or bit advances on the cycle the counter reaches `CLKS_PER_BIT`-1.
- Push latency: with `done`=1 in cycle c, `fifo_count` reflects the push in cycle c+1.
- Start latency from an idle, empty block:
  - `done` in cycle c.
  - FSM sees the FIFO non-empty in c+1 and pops at the end of c+1.
  - `tx` falls in cycle c+2.
- Frame lengths:
  - one byte frame = 10·`CLKS_PER_BIT` cycles;
  - one word = 20·`CLKS_PER_BIT` cycles of `tx` activity.
- Back-to-back words: after the high-byte STOP ends in cycle t, the FSM is in IDLE for exactly one cycle (t+1), during which it pops. The next start bit begins at t+2.
- `busy` drops to 0 in the first IDLE cycle where the FIFO is empty. That is the cycle after the last STOP bit completes.
- Reset mid-frame: `tx` is 1 in the cycle after the reset edge. The partial frame and all queued words are discarded.

## Test plan

Use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4 in the bench unless stated otherwise.

1. Reset: hold `rst_n`=0 for 3 cycles while toggling `done` and `d_out` → `tx`=1, `busy`=0, `overflow`=0, `fifo_count`=0 throughout and after release.
2. Single word: after reset, pulse `done` for one cycle with `d_out`=16'hA53C.
   - `tx` is low starting 2 cycles later.
   - Decoded frames are 0x3C then 0xA5; each bit is 4 cycles; 80 cycles total.
   - `busy` falls on the cycle after the second stop bit.
3. Burst and overflow: pulse `done` for 6 consecutive cycles with `d_out`=1,2,3,4,5,6.
   - Word 1 is popped in burst cycle 2 (`fifo_count` goes 1→1).
   - Words 2..5 fill the FIFO; word 6 is dropped.
   - `overflow`=1 from the cycle after word 6's push request.
   - `tx` sends 1,2,3,4,5 in order with a 1-cycle IDLE gap between words.
   - `overflow` stays 1 afterwards.
4. Simultaneous push and pop when full: fill the FIFO while a word is in flight. Pulse `done`=1 in the exact cycle the FSM is in IDLE and pops.
   - The push is accepted and `fifo_count` stays at 4.
   - `overflow` stays 0.
5. Reset mid-frame: start sending 16'hFFFF with 2 words queued, then assert `rst_n`=0 for one cycle during DATA bit 3 of the low byte.
   - `tx`=1 on the next cycle; `fifo_count`=0; `busy`=0.
   - No further frames appear.
6. Timing parameter: rerun scenario 2 with `CLKS_PER_BIT`=2 → each bit is 2 cycles; the word completes in 40 cycles.
